// File: rtl/writeback_queue_pkg.sv
// Shared instruction encodings and field helpers for the writeback path.
package writeback_queue_pkg;

    localparam int INSN_W   = 16;
    localparam int REG_W    = 4;
    localparam int CLASS_HI = 15;
    localparam int CLASS_LO = 14;
    localparam int DST_HI   = 13;
    localparam int DST_LO   = 10;

    typedef enum logic [1:0] {
        CLASS_ALU  = 2'b00,
        CLASS_NOP1 = 2'b01,
        CLASS_LOAD = 2'b10,
        CLASS_NOP3 = 2'b11
    } insn_class_e;

    function automatic insn_class_e insn_class(input logic [INSN_W-1:0] insn);
        return insn_class_e'(insn[CLASS_HI:CLASS_LO]);
    endfunction

    function automatic logic [REG_W-1:0] insn_dst(input logic [INSN_W-1:0] insn);
        return insn[DST_HI:DST_LO];
    endfunction

    // r0 is hard-wired zero, so writes aimed at it are discarded up front.
    function automatic logic insn_writes(input logic [INSN_W-1:0] insn);
        insn_class_e c;
        c = insn_class(insn);
        return ((c == CLASS_ALU) || (c == CLASS_LOAD)) && (insn_dst(insn) != '0);
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Instruction intake and register-file write port of the writeback queue.
interface writeback_queue_if #(parameter int DATA_W = 16);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_insn;
    logic [DATA_W-1:0] in_alu_value;
    logic [DATA_W-1:0] mem_ro_port_value;
    logic              regfile_wo_port_enable;
    logic              regfile_wo_port_ready;
    logic [3:0]        regfile_wo_port_reg_num;
    logic [DATA_W-1:0] regfile_wo_port_value;

    modport master (
        output in_valid, in_insn, in_alu_value, mem_ro_port_value, regfile_wo_port_ready,
        input  in_ready, regfile_wo_port_enable, regfile_wo_port_reg_num, regfile_wo_port_value
    );

    modport slave (
        input  in_valid, in_insn, in_alu_value, mem_ro_port_value, regfile_wo_port_ready,
        output in_ready, regfile_wo_port_enable, regfile_wo_port_reg_num, regfile_wo_port_value
    );
endinterface

// File: rtl/writeback_queue_wb_fifo.sv
// Pending-write FIFO; entries are also presented in age order (index 0 = head)
// so the owner can search them for the youngest write to a register.
module wb_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           ord_data_o [DEPTH],
    output logic [DEPTH-1:0]           ord_valid_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok = push_i && (count_q < CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
        logic [PTR_W:0]   raw;
        logic [PTR_W-1:0] idx;
        assign raw = {1'b0, rd_ptr_q} + (PTR_W+1)'(gi);
        assign idx = (raw >= (PTR_W+1)'(DEPTH)) ? PTR_W'(raw - (PTR_W+1)'(DEPTH)) : PTR_W'(raw);
        assign ord_data_o[gi]  = mem_q[idx];
        assign ord_valid_o[gi] = (CNT_W'(gi) < count_q);
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage: one capture stage (resolves load data) feeding a pending-write
// queue that drains into the register file, with a youngest-write bypass lookup.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    writeback_queue_if.slave   bus,
    input  logic [REG_W-1:0]   query_reg_num,
    output logic               query_hit,
    output logic [DATA_W-1:0]  query_value,
    output logic [15:0]        retired_count
);
    localparam int ENTRY_W = DATA_W + REG_W;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic              s1_writes_q;
    insn_class_e       s1_class_q;
    logic [REG_W-1:0]  s1_dst_q;
    logic [DATA_W-1:0] s1_alu_q;
    logic [15:0]       retired_q;

    logic               accept, pop;
    logic [DATA_W-1:0]  s1_value;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] ord_data [DEPTH];
    logic [DEPTH-1:0]   ord_valid;

    // No credit for a same-cycle pop keeps in_ready off the regfile ready path.
    assign bus.in_ready = ({1'b0, fifo_count} + (CNT_W+1)'(s1_writes_q)) < (CNT_W+1)'(DEPTH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign s1_value     = (s1_class_q == CLASS_LOAD) ? bus.mem_ro_port_value : s1_alu_q;
    assign pop          = ord_valid[0] && bus.regfile_wo_port_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_writes_q <= 1'b0;
            s1_class_q  <= CLASS_ALU;
            s1_dst_q    <= '0;
            s1_alu_q    <= '0;
            retired_q   <= '0;
        end else begin
            s1_writes_q <= accept && insn_writes(bus.in_insn);
            if (accept) begin
                s1_class_q <= insn_class(bus.in_insn);
                s1_dst_q   <= insn_dst(bus.in_insn);
                s1_alu_q   <= bus.in_alu_value;
            end
            if (pop) retired_q <= retired_q + 16'd1;
        end
    end

    wb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (s1_writes_q),
        .push_data_i ({s1_dst_q, s1_value}),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .ord_data_o  (ord_data),
        .ord_valid_o (ord_valid)
    );

    assign bus.regfile_wo_port_enable  = ord_valid[0];
    assign bus.regfile_wo_port_reg_num = ord_valid[0] ? ord_data[0][ENTRY_W-1:DATA_W] : '0;
    assign bus.regfile_wo_port_value   = ord_valid[0] ? ord_data[0][DATA_W-1:0] : '0;
    assign retired_count               = retired_q;

    // Later matches override earlier ones: head to tail, then stage 1 (youngest).
    always_comb begin
        query_hit   = 1'b0;
        query_value = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ord_valid[k] && (ord_data[k][ENTRY_W-1:DATA_W] == query_reg_num)) begin
                query_hit   = 1'b1;
                query_value = ord_data[k][DATA_W-1:0];
            end
        end
        if (s1_writes_q && (s1_dst_q == query_reg_num)) begin
            query_hit   = 1'b1;
            query_value = s1_value;
        end
        if (query_reg_num == '0) begin
            query_hit   = 1'b0;
            query_value = '0;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench: stimulus pushes expected register writes, a negedge monitor
// pops and compares them as the register-file port retires writes.
module tb_writeback_queue;
    logic clk;
    logic rst_n, rst4_n;
    logic [3:0]  query_reg_num, query4;
    logic        query_hit, query4_hit;
    logic [15:0] query_value, query4_value;
    logic [15:0] retired_count, retired4;

    writeback_queue_if #(.DATA_W(16)) bus();
    writeback_queue_if #(.DATA_W(16)) bus4();

    writeback_queue #(.DATA_W(16), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .query_reg_num(query_reg_num), .query_hit(query_hit),
        .query_value(query_value), .retired_count(retired_count)
    );

    writeback_queue #(.DATA_W(16), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(bus4),
        .query_reg_num(query4), .query_hit(query4_hit),
        .query_value(query4_value), .retired_count(retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;
    int enable_cycles = 0;
    int pops4 = 0;
    int err4 = 0;
    logic [19:0] expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.regfile_wo_port_enable) begin
            enable_cycles++;
            if (bus.regfile_wo_port_ready) begin
                if (expq.size() == 0) begin
                    test_cnt++;
                    fail_cnt++;
                    $display("[TB] FAIL unexpected_write: got r%0d=0x%0h expected none",
                             bus.regfile_wo_port_reg_num, bus.regfile_wo_port_value);
                end else begin
                    logic [19:0] e;
                    e = expq.pop_front();
                    check("wb_write", {12'h0, bus.regfile_wo_port_reg_num, bus.regfile_wo_port_value},
                          {12'h0, e});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst4_n && bus4.regfile_wo_port_enable && bus4.regfile_wo_port_ready) begin
            if (bus4.regfile_wo_port_value !== 16'(pops4) || bus4.regfile_wo_port_reg_num !== 4'd1)
                err4++;
            pops4++;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic send(input logic [1:0] cls, input logic [3:0] rd,
                        input logic [15:0] alu, input logic [15:0] memv);
        int waitc = 0;
        bus.in_valid     = 1'b1;
        bus.in_insn      = {cls, rd, 10'h0};
        bus.in_alu_value = alu;
        @(negedge clk);
        while (!bus.in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid          = 1'b0;
        bus.mem_ro_port_value = memv;
        if ((cls == 2'b00 || cls == 2'b10) && rd != 4'd0)
            expq.push_back({rd, (cls == 2'b10) ? memv : alu});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        expq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || bus.regfile_wo_port_enable) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(expq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, guard;
        logic rdy;
        rst_n = 1'b0; rst4_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_insn = '0; bus.in_alu_value = '0;
        bus.mem_ro_port_value = '0; bus.regfile_wo_port_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_insn = '0; bus4.in_alu_value = '0;
        bus4.mem_ro_port_value = '0; bus4.regfile_wo_port_ready = 1'b0;
        query_reg_num = 4'd0; query4 = 4'd0;

        #3;
        check("rst_enable",  32'(bus.regfile_wo_port_enable), 32'd0);
        check("rst_reg_num", 32'(bus.regfile_wo_port_reg_num), 32'd0);
        check("rst_value",   32'(bus.regfile_wo_port_value), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_retired", 32'(retired_count), 32'd0);
        check("rst_query_hit", 32'(query_hit), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Load r3 with memory data 0x1234, enable two cycles after acceptance.
        bus.regfile_wo_port_ready = 1'b1;
        send(2'b10, 4'd3, 16'hAAAA, 16'h1234);
        @(negedge clk);
        check("load_lat_cycle1_enable", 32'(bus.regfile_wo_port_enable), 32'd0);
        @(negedge clk);
        check("load_lat_cycle2_enable", 32'(bus.regfile_wo_port_enable), 32'd1);
        check("load_reg_num", 32'(bus.regfile_wo_port_reg_num), 32'd3);
        check("load_value", 32'(bus.regfile_wo_port_value), 32'h1234);
        drain();
        check("load_retired", 32'(retired_count), 32'd1);

        // r0 write and non-writing class never reach the register file.
        do_reset();
        bus.regfile_wo_port_ready = 1'b1;
        enable_cycles = 0;
        send(2'b00, 4'd0, 16'hFFFF, 16'h0);
        send(2'b01, 4'd5, 16'h5555, 16'h0);
        repeat (6) @(posedge clk); #1;
        check("nowrite_enable_cycles", 32'(enable_cycles), 32'd0);
        check("nowrite_retired", 32'(retired_count), 32'd0);

        // Backpressure: two in flight fills DEPTH=2, then in-order drain.
        do_reset();
        bus.regfile_wo_port_ready = 1'b0;
        fork
            begin
                send(2'b00, 4'd1, 16'h0011, 16'h0);
                send(2'b00, 4'd2, 16'h0022, 16'h0);
                send(2'b00, 4'd3, 16'h0033, 16'h0);
                send(2'b00, 4'd4, 16'h0044, 16'h0);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_head_reg", 32'(bus.regfile_wo_port_reg_num), 32'd1);
                @(negedge clk);
                check("bp_head_stable", 32'(bus.regfile_wo_port_value), 32'h0011);
                @(posedge clk); #1 bus.regfile_wo_port_ready = 1'b1;
            end
        join
        drain();
        check("bp_retired", 32'(retired_count), 32'd4);

        // Query: youngest pending write to r7 wins, stage 1 first then queue.
        do_reset();
        bus.regfile_wo_port_ready = 1'b0;
        send(2'b00, 4'd7, 16'h0001, 16'h0);
        send(2'b00, 4'd7, 16'h0002, 16'h0);
        query_reg_num = 4'd7; #1;
        check("query_s1_hit", 32'(query_hit), 32'd1);
        check("query_s1_value", 32'(query_value), 32'h0002);
        @(posedge clk); #1;
        check("query_q_hit", 32'(query_hit), 32'd1);
        check("query_q_value", 32'(query_value), 32'h0002);
        check("query_full_in_ready", 32'(bus.in_ready), 32'd0);
        query_reg_num = 4'd5; #1;
        check("query_miss_hit", 32'(query_hit), 32'd0);
        query_reg_num = 4'd0; #1;
        check("query_r0_hit", 32'(query_hit), 32'd0);
        check("query_r0_value", 32'(query_value), 32'd0);

        // Asynchronous reset with two queued writes discards them.
        check("pre_rst_enable", 32'(bus.regfile_wo_port_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_enable", 32'(bus.regfile_wo_port_enable), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        expq.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        bus.regfile_wo_port_ready = 1'b1;
        enable_cycles = 0;
        repeat (5) @(posedge clk); #1;
        check("midrst_no_issue", 32'(enable_cycles), 32'd0);
        check("midrst_retired", 32'(retired_count), 32'd0);

        // A load sitting in stage 1 is dropped by reset.
        send(2'b10, 4'd9, 16'h0, 16'hBEEF);
        #1 rst_n = 1'b0;
        expq.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        enable_cycles = 0;
        repeat (5) @(posedge clk); #1;
        check("s1_load_dropped", 32'(enable_cycles), 32'd0);

        // 65537 retirements on a DEPTH=4 instance wrap retired_count to 1.
        rst4_n = 1'b1;
        bus4.regfile_wo_port_ready = 1'b1;
        bus4.in_valid = 1'b1;
        bus4.in_insn  = {2'b00, 4'd1, 10'h0};
        acc = 0; guard = 0;
        while (acc < 65537 && guard < 90000) begin
            bus4.in_alu_value = 16'(acc);
            @(negedge clk);
            rdy = bus4.in_ready;
            @(posedge clk); #1;
            if (rdy) acc++;
            guard++;
        end
        bus4.in_valid = 1'b0;
        guard = 0;
        while (pops4 < 65537 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk); #1;
        check("wrap_pops", 32'(pops4), 32'd65537);
        check("wrap_order_errors", 32'(err4), 32'd0);
        check("wrap_retired", 32'(retired4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
